// File: rtl/switch.sv
// Address-split packet switch: one input stream routed to port A (addr <= ADDR_DIV) or port B.
// Optional per-port packet counters are compiled in when SWITCH_CNT_EN is defined.
module switch #(
  parameter int unsigned              ADDR_WIDTH = 8,
  parameter int unsigned              DATA_WIDTH = 16,
  parameter logic [ADDR_WIDTH-1:0]    ADDR_DIV   = 8'h3F
`ifdef SWITCH_CNT_EN
  ,
  parameter int unsigned              CNT_WIDTH  = 16
`endif
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] data,
  input  logic                  vld,
  output logic [ADDR_WIDTH-1:0] addr_a,
  output logic [DATA_WIDTH-1:0] data_a,
  output logic                  vld_a,
  output logic [ADDR_WIDTH-1:0] addr_b,
  output logic [DATA_WIDTH-1:0] data_b,
  output logic                  vld_b
`ifdef SWITCH_CNT_EN
  ,
  output logic [CNT_WIDTH-1:0]  cnt_a,
  output logic [CNT_WIDTH-1:0]  cnt_b
`endif
);

  logic                  sel_a_s;
  logic [ADDR_WIDTH-1:0] addr_a_d, addr_a_q;
  logic [DATA_WIDTH-1:0] data_a_d, data_a_q;
  logic                  vld_a_d,  vld_a_q;
  logic [ADDR_WIDTH-1:0] addr_b_d, addr_b_q;
  logic [DATA_WIDTH-1:0] data_b_d, data_b_q;
  logic                  vld_b_d,  vld_b_q;

  assign sel_a_s = (addr <= ADDR_DIV);

  // Route the input to exactly one port; the idle port and idle cycles read all-zero.
  always_comb begin
    addr_a_d = '0;
    data_a_d = '0;
    vld_a_d  = 1'b0;
    addr_b_d = '0;
    data_b_d = '0;
    vld_b_d  = 1'b0;
    if (vld) begin
      if (sel_a_s) begin
        addr_a_d = addr;
        data_a_d = data;
        vld_a_d  = 1'b1;
      end else begin
        addr_b_d = addr;
        data_b_d = data;
        vld_b_d  = 1'b1;
      end
    end else begin
      vld_a_d  = 1'b0;
      vld_b_d  = 1'b0;
    end
  end

  // Output registers, cleared asynchronously so a reset drops any in-flight packet.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      addr_a_q <= '0;
      data_a_q <= '0;
      vld_a_q  <= 1'b0;
      addr_b_q <= '0;
      data_b_q <= '0;
      vld_b_q  <= 1'b0;
    end else begin
      addr_a_q <= addr_a_d;
      data_a_q <= data_a_d;
      vld_a_q  <= vld_a_d;
      addr_b_q <= addr_b_d;
      data_b_q <= data_b_d;
      vld_b_q  <= vld_b_d;
    end
  end

  assign addr_a = addr_a_q;
  assign data_a = data_a_q;
  assign vld_a  = vld_a_q;
  assign addr_b = addr_b_q;
  assign data_b = data_b_q;
  assign vld_b  = vld_b_q;

`ifdef SWITCH_CNT_EN
  localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

  logic [CNT_WIDTH-1:0] cnt_a_d, cnt_a_q;
  logic [CNT_WIDTH-1:0] cnt_b_d, cnt_b_q;

  // Count packets loaded into each port; natural overflow gives the wrap to zero.
  always_comb begin
    cnt_a_d = cnt_a_q;
    cnt_b_d = cnt_b_q;
    if (vld_a_d) begin
      cnt_a_d = cnt_a_q + CNT_ONE;
    end else begin
      cnt_a_d = cnt_a_q;
    end
    if (vld_b_d) begin
      cnt_b_d = cnt_b_q + CNT_ONE;
    end else begin
      cnt_b_d = cnt_b_q;
    end
  end

  // Counter registers.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt_a_q <= '0;
      cnt_b_q <= '0;
    end else begin
      cnt_a_q <= cnt_a_d;
      cnt_b_q <= cnt_b_d;
    end
  end

  assign cnt_a = cnt_a_q;
  assign cnt_b = cnt_b_q;
`endif

endmodule

// File: tb/tb_switch.sv
// Directed self-checking bench for switch; counter checks are compiled in with SWITCH_CNT_EN.
module tb_switch;

  logic        clk;
  logic        rstn;
  logic [7:0]  addr;
  logic [15:0] data;
  logic        vld;
  logic [7:0]  addr_a;
  logic [15:0] data_a;
  logic        vld_a;
  logic [7:0]  addr_b;
  logic [15:0] data_b;
  logic        vld_b;
`ifdef SWITCH_CNT_EN
  logic [15:0] cnt_a;
  logic [15:0] cnt_b;
`endif

  int vectors = 0;
  int errors  = 0;

  switch dut (
    .clk    (clk),
    .rstn   (rstn),
    .addr   (addr),
    .data   (data),
    .vld    (vld),
    .addr_a (addr_a),
    .data_a (data_a),
    .vld_a  (vld_a),
    .addr_b (addr_b),
    .data_b (data_b),
    .vld_b  (vld_b)
`ifdef SWITCH_CNT_EN
    ,
    .cnt_a  (cnt_a),
    .cnt_b  (cnt_b)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic expect_ports(input string tag,
                              input logic [7:0] ea, input logic [15:0] ed, input logic ev,
                              input logic [7:0] eb, input logic [15:0] edb, input logic evb);
    check({tag, ".addr_a"}, {24'd0, addr_a}, {24'd0, ea});
    check({tag, ".data_a"}, {16'd0, data_a}, {16'd0, ed});
    check({tag, ".vld_a"},  {31'd0, vld_a},  {31'd0, ev});
    check({tag, ".addr_b"}, {24'd0, addr_b}, {24'd0, eb});
    check({tag, ".data_b"}, {16'd0, data_b}, {16'd0, edb});
    check({tag, ".vld_b"},  {31'd0, vld_b},  {31'd0, evb});
  endtask

  task automatic expect_cnt(input string tag, input logic [15:0] ea, input logic [15:0] eb);
`ifdef SWITCH_CNT_EN
    check({tag, ".cnt_a"}, {16'd0, cnt_a}, {16'd0, ea});
    check({tag, ".cnt_b"}, {16'd0, cnt_b}, {16'd0, eb});
`endif
  endtask

  // Apply one input vector, clock it in, and return 1 time unit after the edge.
  task automatic step(input logic [7:0] a, input logic [15:0] d, input logic v);
    addr = a;
    data = d;
    vld  = v;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rstn = 1'b0;
    addr = 8'h10;
    data = 16'h0000;
    vld  = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    expect_ports("reset", 8'h00, 16'h0000, 1'b0, 8'h00, 16'h0000, 1'b0);
    expect_cnt("reset", 16'd0, 16'd0);

    @(negedge clk);
    rstn = 1'b1;

    step(8'h10, 16'h1234, 1'b1);
    expect_ports("port_a", 8'h10, 16'h1234, 1'b1, 8'h00, 16'h0000, 1'b0);
    expect_cnt("port_a", 16'd1, 16'd0);

    step(8'h3F, 16'hAAAA, 1'b1);
    expect_ports("bound_div", 8'h3F, 16'hAAAA, 1'b1, 8'h00, 16'h0000, 1'b0);
    expect_cnt("bound_div", 16'd2, 16'd0);

    step(8'h40, 16'h5555, 1'b1);
    expect_ports("bound_div1", 8'h00, 16'h0000, 1'b0, 8'h40, 16'h5555, 1'b1);
    expect_cnt("bound_div1", 16'd2, 16'd1);

    step(8'h80, 16'hFFFF, 1'b0);
    expect_ports("idle", 8'h00, 16'h0000, 1'b0, 8'h00, 16'h0000, 1'b0);
    expect_cnt("idle", 16'd2, 16'd1);

    step(8'h00, 16'h0F0F, 1'b1);
    expect_ports("addr_zero", 8'h00, 16'h0F0F, 1'b1, 8'h00, 16'h0000, 1'b0);

    step(8'hFF, 16'hBEEF, 1'b1);
    expect_ports("addr_ones", 8'h00, 16'h0000, 1'b0, 8'hFF, 16'hBEEF, 1'b1);
    expect_cnt("edges", 16'd3, 16'd2);

    step(8'h01, 16'h1111, 1'b1);
    expect_ports("b2b_0", 8'h01, 16'h1111, 1'b1, 8'h00, 16'h0000, 1'b0);
    step(8'hC0, 16'h2222, 1'b1);
    expect_ports("b2b_1", 8'h00, 16'h0000, 1'b0, 8'hC0, 16'h2222, 1'b1);
    step(8'h01, 16'h3333, 1'b1);
    expect_ports("b2b_2", 8'h01, 16'h3333, 1'b1, 8'h00, 16'h0000, 1'b0);
    step(8'hC0, 16'h4444, 1'b1);
    expect_ports("b2b_3", 8'h00, 16'h0000, 1'b0, 8'hC0, 16'h4444, 1'b1);
    expect_cnt("b2b", 16'd5, 16'd4);

    #2;
    rstn = 1'b0;
    #1;
    expect_ports("midrst", 8'h00, 16'h0000, 1'b0, 8'h00, 16'h0000, 1'b0);
    expect_cnt("midrst", 16'd0, 16'd0);

    @(negedge clk);
    rstn = 1'b1;
    step(8'h05, 16'h0A0A, 1'b1);
    expect_ports("post_rst", 8'h05, 16'h0A0A, 1'b1, 8'h00, 16'h0000, 1'b0);
    expect_cnt("post_rst", 16'd1, 16'd0);

    step(8'h05, 16'h0A0A, 1'b0);
    expect_ports("drain", 8'h00, 16'h0000, 1'b0, 8'h00, 16'h0000, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
